stm32_bus_master: RTL and testbench

- Initiator end of the 8-bit DATA_BUS / DATA_SYNC command interface used between the STM32 and the FPGA DDC core.
- Issues one command per transaction: sync cycle, then fixed-length byte write and/or read phases. Collects responder data into parallel result registers.
- Used in the test harness and on the bridge board, where an FPGA acts as host to the transceiver FPGA. Commands 0..6 are supported; 7 (flash read, open-ended) is rejected.

---
 rtl/stm32_bus_pkg.sv | 52 +++++
 rtl/stm32_bus_master.sv | 233 +++++++++++++++++++++++
 tb/tb_stm32_bus_master.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stm32_bus_pkg.sv
// Shared definitions for the STM32 <-> DDC core DATA_BUS / DATA_SYNC command interface.
package stm32_bus_pkg;

  // Command codes carried in the SYNC byte
  localparam logic [2:0] CMD_BUS_TEST    = 3'd0;
  localparam logic [2:0] CMD_GET_PARAMS  = 3'd1;
  localparam logic [2:0] CMD_SEND_PARAMS = 3'd2;
  localparam logic [2:0] CMD_TX_IQ       = 3'd3;
  localparam logic [2:0] CMD_RX_IQ       = 3'd4;
  localparam logic [2:0] CMD_PLL_ON      = 3'd5;
  localparam logic [2:0] CMD_PLL_OFF     = 3'd6;
  localparam logic [2:0] CMD_FLASH_READ  = 3'd7;

  // Fixed byte counts of the write and read phases
  localparam logic [3:0] WR_LEN_BUS_TEST   = 4'd1;
  localparam logic [3:0] WR_LEN_GET_PARAMS = 4'd10;
  localparam logic [3:0] WR_LEN_TX_IQ      = 4'd4;
  localparam logic [3:0] RD_LEN_BUS_TEST   = 4'd1;
  localparam logic [3:0] RD_LEN_SEND_PARAMS = 4'd5;
  localparam logic [3:0] RD_LEN_RX_IQ      = 4'd8;

  // Bus released for one cycle before the first byte of a read-only command
  localparam int TURN_CYCLES = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_WRITE,
    ST_TURN,
    ST_READ,
    ST_GAP
  } state_e;

  function automatic logic [3:0] wr_len(input logic [2:0] cmd);
    case (cmd)
      CMD_BUS_TEST:   return WR_LEN_BUS_TEST;
      CMD_GET_PARAMS: return WR_LEN_GET_PARAMS;
      CMD_TX_IQ:      return WR_LEN_TX_IQ;
      default:        return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] rd_len(input logic [2:0] cmd);
    case (cmd)
      CMD_BUS_TEST:    return RD_LEN_BUS_TEST;
      CMD_SEND_PARAMS: return RD_LEN_SEND_PARAMS;
      CMD_RX_IQ:       return RD_LEN_RX_IQ;
      default:         return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/stm32_bus_master.sv
// Initiator for the 8-bit DATA_BUS / DATA_SYNC command bus. One command per
// transaction: SYNC byte, fixed-length write and/or read phases, then a gap.
// The state register describes the bus cycle about to start; every bus-facing
// output is registered from it, so bus activity trails the state by one cycle.
module stm32_bus_master
  import stm32_bus_pkg::*;
#(
  parameter int          GAP_CYCLES   = 2,
  parameter logic [7:0]  TEST_PATTERN = 8'hA5
) (
  input  logic               clk_in,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_code,
  input  logic [7:0]         ctrl_byte,
  input  logic [21:0]        freq_in,
  input  logic [7:0]         cic_gain,
  input  logic [7:0]         cicfir_gain,
  input  logic [7:0]         tx_cicfir_gain,
  input  logic [7:0]         dac_gain,
  input  logic signed [15:0] adc_offset,
  input  logic signed [15:0] tx_i,
  input  logic signed [15:0] tx_q,
  inout  wire  [7:0]         DATA_BUS,
  output logic               DATA_SYNC,
  output logic               resp_valid,
  output logic               cmd_error,
  output logic               bus_test_ok,
  output logic               adc_otr,
  output logic               dac_otr,
  output logic signed [15:0] adc_min,
  output logic signed [15:0] adc_max,
  output logic signed [15:0] spec_i,
  output logic signed [15:0] spec_q,
  output logic signed [15:0] voice_i,
  output logic signed [15:0] voice_q
);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [2:0]  cmd_q;
  logic        ready_q;

  // Payload shadow registers, captured at accept
  logic [7:0]  ctrl_q, cic_q, cicfir_q, tx_cicfir_q, dac_q;
  logic [21:0] freq_q;
  logic [15:0] offset_q, tx_i_q, tx_q_q;

  // Registered bus-side outputs
  logic        sync_q, bus_oe_q, rd_q, resp_valid_q, cmd_error_q;
  logic [7:0]  bus_out_q;

  // 64-bit sample window: 56 stored bits plus the byte on the bus this cycle
  logic [55:0] shift_q;
  logic [63:0] shift_next;

  logic [7:0]  wr_byte;
  logic [3:0]  wr_n, rd_n;
  logic        accept, res_load;

  assign wr_n       = wr_len(cmd_q);
  assign rd_n       = rd_len(cmd_q);
  assign accept     = cmd_valid && ready_q;
  assign shift_next = {shift_q, DATA_BUS};
  // The previous bus cycle was the final read byte exactly when the first gap cycle is being prepared
  assign res_load   = (state_q == ST_GAP) && (cnt_q == 4'd0) && (rd_n != 4'd0);

  assign DATA_BUS   = bus_oe_q ? bus_out_q : 8'bz;
  assign DATA_SYNC  = sync_q;
  assign cmd_ready  = ready_q;
  assign resp_valid = resp_valid_q;
  assign cmd_error  = cmd_error_q;

  // Byte mux: write-phase byte selected by command and byte index
  always_comb begin
    // NOTE: default assignment first so no path leaves wr_byte unassigned (no latch).
    wr_byte = 8'h00;
    case (cmd_q)
      CMD_GET_PARAMS: begin
        case (cnt_q)
          4'd0:    wr_byte = ctrl_q;
          4'd1:    wr_byte = {2'b00, freq_q[21:16]};
          4'd2:    wr_byte = freq_q[15:8];
          4'd3:    wr_byte = freq_q[7:0];
          4'd4:    wr_byte = cic_q;
          4'd5:    wr_byte = cicfir_q;
          4'd6:    wr_byte = tx_cicfir_q;
          4'd7:    wr_byte = dac_q;
          4'd8:    wr_byte = offset_q[15:8];
          4'd9:    wr_byte = offset_q[7:0];
          default: wr_byte = 8'h00;
        endcase
      end
      CMD_TX_IQ: begin
        case (cnt_q)
          4'd0:    wr_byte = tx_q_q[15:8];
          4'd1:    wr_byte = tx_q_q[7:0];
          4'd2:    wr_byte = tx_i_q[15:8];
          4'd3:    wr_byte = tx_i_q[7:0];
          default: wr_byte = 8'h00;
        endcase
      end
      CMD_BUS_TEST: wr_byte = TEST_PATTERN;
      default:      wr_byte = 8'h00;
    endcase
  end

  // Transaction FSM with registered bus outputs, sample shifter and result registers
  always_ff @(posedge clk_in or negedge reset_n) begin
    // NOTE: everything here is reset, including shadow and result registers, so reset mid-command leaves no stale state.
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      cmd_q        <= 3'd0;
      ready_q      <= 1'b1;
      ctrl_q       <= '0;
      freq_q       <= '0;
      cic_q        <= '0;
      cicfir_q     <= '0;
      tx_cicfir_q  <= '0;
      dac_q        <= '0;
      offset_q     <= '0;
      tx_i_q       <= '0;
      tx_q_q       <= '0;
      sync_q       <= 1'b0;
      bus_oe_q     <= 1'b0;
      bus_out_q    <= '0;
      rd_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      cmd_error_q  <= 1'b0;
      shift_q      <= '0;
      bus_test_ok  <= 1'b0;
      adc_otr      <= 1'b0;
      dac_otr      <= 1'b0;
      adc_min      <= '0;
      adc_max      <= '0;
      spec_i       <= '0;
      spec_q       <= '0;
      voice_i      <= '0;
      voice_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
      sync_q       <= (state_q == ST_SYNC);
      bus_oe_q     <= (state_q == ST_SYNC) || (state_q == ST_WRITE);
      bus_out_q    <= (state_q == ST_SYNC) ? {5'b00000, cmd_q} : wr_byte;
      rd_q         <= (state_q == ST_READ);
      resp_valid_q <= (state_q == ST_GAP) && (cnt_q == 4'd0);
      cmd_error_q  <= (state_q == ST_GAP) && (cnt_q == 4'd0) && (cmd_q == CMD_FLASH_READ);
      ready_q      <= accept ? 1'b0 : (state_q == ST_IDLE);

      if (rd_q) shift_q <= shift_next[55:0];

      if (res_load) begin
        case (cmd_q)
          CMD_BUS_TEST: bus_test_ok <= (shift_next[7:0] == TEST_PATTERN);
          CMD_SEND_PARAMS: begin
            adc_otr <= shift_next[32];
            dac_otr <= shift_next[33];
            adc_min <= shift_next[31:16];
            adc_max <= shift_next[15:0];
          end
          CMD_RX_IQ: begin
            spec_q  <= shift_next[63:48];
            spec_i  <= shift_next[47:32];
            voice_q <= shift_next[31:16];
            voice_i <= shift_next[15:0];
          end
          default: ;
        endcase
      end

      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            cmd_q       <= cmd_code;
            ctrl_q      <= ctrl_byte;
            freq_q      <= freq_in;
            cic_q       <= cic_gain;
            cicfir_q    <= cicfir_gain;
            tx_cicfir_q <= tx_cicfir_gain;
            dac_q       <= dac_gain;
            offset_q    <= adc_offset;
            tx_i_q      <= tx_i;
            tx_q_q      <= tx_q;
            cnt_q       <= 4'd0;
            state_q     <= (cmd_code == CMD_FLASH_READ) ? ST_GAP : ST_SYNC;
          end
        end
        ST_SYNC: begin
          cnt_q <= 4'd0;
          if (wr_n != 4'd0)      state_q <= ST_WRITE;
          else if (rd_n != 4'd0) state_q <= ST_TURN;
          else                   state_q <= ST_GAP;
        end
        ST_WRITE: begin
          if (cnt_q == wr_n - 4'd1) begin
            cnt_q   <= 4'd0;
            state_q <= (rd_n != 4'd0) ? ST_READ : ST_GAP;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ST_TURN: begin
          if (cnt_q == 4'(TURN_CYCLES - 1)) begin
            cnt_q   <= 4'd0;
            state_q <= ST_READ;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ST_READ: begin
          if (cnt_q == rd_n - 4'd1) begin
            cnt_q   <= 4'd0;
            state_q <= ST_GAP;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ST_GAP: begin
          if (cnt_q == 4'(GAP_CYCLES - 1)) begin
            cnt_q   <= 4'd0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stm32_bus_master.sv
// Scoreboard bench for stm32_bus_master: stimulus pushes expected bus bytes and
// responses into queues; a monitor pops and compares whenever the DUT drives
// the bus or pulses resp_valid. A behavioural responder answers read phases.
module tb_stm32_bus_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_code = 3'd0;
  logic [7:0]  ctrl_byte = 8'h00;
  logic [21:0] freq_in = 22'd0;
  logic [7:0]  cic_gain = 8'h00, cicfir_gain = 8'h00, tx_cicfir_gain = 8'h00, dac_gain = 8'h00;
  logic [15:0] adc_offset = 16'h0000, tx_i = 16'h0000, tx_q = 16'h0000;
  wire  [7:0]  data_bus;
  logic        data_sync, resp_valid, cmd_error, bus_test_ok, adc_otr, dac_otr;
  logic [15:0] adc_min, adc_max, spec_i, spec_q, voice_i, voice_q;

  always #5 clk = ~clk;

  stm32_bus_master #(.GAP_CYCLES(2), .TEST_PATTERN(8'hA5)) dut (
    .clk_in(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code),
    .ctrl_byte(ctrl_byte), .freq_in(freq_in),
    .cic_gain(cic_gain), .cicfir_gain(cicfir_gain),
    .tx_cicfir_gain(tx_cicfir_gain), .dac_gain(dac_gain),
    .adc_offset(adc_offset), .tx_i(tx_i), .tx_q(tx_q),
    .DATA_BUS(data_bus), .DATA_SYNC(data_sync),
    .resp_valid(resp_valid), .cmd_error(cmd_error), .bus_test_ok(bus_test_ok),
    .adc_otr(adc_otr), .dac_otr(dac_otr), .adc_min(adc_min), .adc_max(adc_max),
    .spec_i(spec_i), .spec_q(spec_q), .voice_i(voice_i), .voice_q(voice_q)
  );

  typedef struct {
    logic        err, tok, aotr, dotr;
    logic [15:0] amin, amax, si, sq, vi, vq;
    int          cyc;
  } resp_t;

  typedef struct {
    logic       sync;
    logic [7:0] b;
  } busb_t;

  resp_t      resp_q[$];
  busb_t      bus_q[$];
  resp_t      model;
  logic [7:0] rsp_fifo[$];

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Responder model state
  logic       rsp_oe = 1'b0;
  logic [7:0] rsp_byte = 8'h00;
  logic [7:0] lb_byte = 8'h00;
  logic [2:0] rcmd = 3'd0;
  int         rcyc = -1;
  bit         lb_corrupt = 1'b0;

  assign data_bus = (rsp_oe && reset_n) ? rsp_byte : 8'hzz;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  task automatic push_bus(input logic s, input logic [7:0] b);
    busb_t x;
    x.sync = s;
    x.b    = b;
    bus_q.push_back(x);
  endtask

  function automatic resp_t zero_resp();
    resp_t r;
    r.err = 0; r.tok = 0; r.aotr = 0; r.dotr = 0;
    r.amin = 0; r.amax = 0; r.si = 0; r.sq = 0; r.vi = 0; r.vq = 0;
    r.cyc = 0;
    return r;
  endfunction

  // Responder: registers what it sees, drives read data one cycle after turnaround
  initial begin
    logic       s_sync;
    logic [7:0] s_bus;
    forever begin
      @(negedge clk);
      s_sync = data_sync;
      s_bus  = data_bus;
      @(posedge clk);
      #1;
      rsp_oe = 1'b0;
      if (!reset_n) rcyc = -1;
      else if (s_sync) begin
        rcyc = 1;
        rcmd = s_bus[2:0];
      end else if (rcyc >= 0) begin
        if (rcyc == 1) lb_byte = s_bus;
        rcyc++;
        if (rcyc > 12) rcyc = -1;
      end
      if (rcyc >= 2) begin
        case (rcmd)
          3'd0: if (rcyc == 2) begin
            rsp_oe   = 1'b1;
            rsp_byte = lb_corrupt ? 8'h5A : lb_byte;
          end
          3'd2, 3'd4: if (rsp_fifo.size() > 0) begin
            rsp_oe   = 1'b1;
            rsp_byte = rsp_fifo.pop_front();
          end
          default: ;
        endcase
      end
    end
  end

  // Monitor: compares bus bytes while the master drives, and responses on resp_valid
  initial begin
    logic  prev_sync;
    busb_t x;
    resp_t e;
    prev_sync = 1'b0;
    forever begin
      @(negedge clk);
      if (dut.bus_oe_q) begin
        if (bus_q.size() == 0) fail("unexpected_bus_drive");
        else begin
          x = bus_q.pop_front();
          check("bus_byte", 64'(data_bus), 64'(x.b));
          check("bus_sync", 64'(data_sync), 64'(x.sync));
        end
      end else if (data_sync) fail("sync_while_released");
      if (data_sync) check("sync_consecutive", 64'(prev_sync), 64'(0));
      prev_sync = data_sync;
      if (resp_valid) begin
        if (resp_q.size() == 0) fail("unexpected_resp_valid");
        else begin
          e = resp_q.pop_front();
          check("resp_cycle", 64'(cyc), 64'(e.cyc));
          check("cmd_error", 64'(cmd_error), 64'(e.err));
          check("bus_test_ok", 64'(bus_test_ok), 64'(e.tok));
          check("adc_otr", 64'(adc_otr), 64'(e.aotr));
          check("dac_otr", 64'(dac_otr), 64'(e.dotr));
          check("adc_min", 64'(adc_min), 64'(e.amin));
          check("adc_max", 64'(adc_max), 64'(e.amax));
          check("spec_i", 64'(spec_i), 64'(e.si));
          check("spec_q", 64'(spec_q), 64'(e.sq));
          check("voice_i", 64'(voice_i), 64'(e.vi));
          check("voice_q", 64'(voice_q), 64'(e.vq));
        end
      end
    end
  end

  // Issue one command; lat is accept edge to resp_valid edge in cycles
  task automatic issue(input logic [2:0] code, input int lat, input bit want_resp, input bit drop_valid);
    resp_t e;
    int t;
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) begin
      fail("cmd_ready_timeout");
      return;
    end
    cmd_code  = code;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    if (drop_valid) cmd_valid = 1'b0;
    // Payload changes after accept must not reach the bus
    ctrl_byte = ~ctrl_byte; freq_in = ~freq_in; cic_gain = ~cic_gain;
    cicfir_gain = ~cicfir_gain; tx_cicfir_gain = ~tx_cicfir_gain; dac_gain = ~dac_gain;
    adc_offset = ~adc_offset; tx_i = ~tx_i; tx_q = ~tx_q;
    if (want_resp) begin
      e = model;
      e.cyc = cyc + lat;
      resp_q.push_back(e);
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((resp_q.size() != 0 || bus_q.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (resp_q.size() != 0 || bus_q.size() != 0) begin
      fail("transaction_timeout");
      resp_q.delete();
      bus_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int t;
    model = zero_resp();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    check("rst_data_sync", 64'(data_sync), 64'(0));
    check("rst_resp_valid", 64'(resp_valid), 64'(0));
    check("rst_bus_oe", 64'(dut.bus_oe_q), 64'(0));
    check("rst_results", 64'({spec_q, adc_min, bus_test_ok, cmd_error}), 64'(0));
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // cmd 1: parameter write, 10 bytes
    ctrl_byte = 8'h21; freq_in = 22'd242347;
    cic_gain = 8'd32; cicfir_gain = 8'd32; tx_cicfir_gain = 8'd32; dac_gain = 8'd32;
    adc_offset = 16'hFFFB;
    push_bus(1, 8'h01);
    push_bus(0, 8'h21); push_bus(0, 8'h03); push_bus(0, 8'hB2); push_bus(0, 8'hAB);
    push_bus(0, 8'h20); push_bus(0, 8'h20); push_bus(0, 8'h20); push_bus(0, 8'h20);
    push_bus(0, 8'hFF); push_bus(0, 8'hFB);
    issue(3'd1, 12, 1, 1);
    wait_done();

    // cmd 0: bus test with loopback responder
    lb_corrupt = 1'b0;
    push_bus(1, 8'h00); push_bus(0, 8'hA5);
    model.tok = 1'b1;
    issue(3'd0, 4, 1, 1);
    wait_done();

    // cmd 0: responder returns a wrong byte
    lb_corrupt = 1'b1;
    push_bus(1, 8'h00); push_bus(0, 8'hA5);
    model.tok = 1'b0;
    issue(3'd0, 4, 1, 1);
    wait_done();
    lb_corrupt = 1'b0;

    // cmd 4: RX IQ read, 8 bytes
    rsp_fifo = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hF0, 8'h0F, 8'h80, 8'h00};
    push_bus(1, 8'h04);
    model.sq = 16'h0102; model.si = 16'h0304; model.vq = 16'hF00F; model.vi = 16'h8000;
    issue(3'd4, 11, 1, 1);
    wait_done();

    // cmd 2: status read, 5 bytes (-2000 = F830, 2000 = 07D0)
    rsp_fifo = '{8'hFE, 8'hF8, 8'h30, 8'h07, 8'hD0};
    push_bus(1, 8'h02);
    model.aotr = 1'b0; model.dotr = 1'b1; model.amin = 16'hF830; model.amax = 16'h07D0;
    issue(3'd2, 8, 1, 1);
    wait_done();

    // cmd 3: TX IQ write, Q then I, high byte first
    tx_q = 16'h1234; tx_i = 16'hABCD;
    push_bus(1, 8'h03);
    push_bus(0, 8'h12); push_bus(0, 8'h34); push_bus(0, 8'hAB); push_bus(0, 8'hCD);
    issue(3'd3, 6, 1, 1);
    wait_done();

    // cmd 6: SYNC only
    push_bus(1, 8'h06);
    issue(3'd6, 2, 1, 1);
    wait_done();

    // cmd 5 then cmd 7 with cmd_valid held: 7 accepted after sync, 2 gap cycles, ready cycle
    push_bus(1, 8'h05);
    issue(3'd5, 2, 1, 0);
    cmd_code = 3'd7;
    begin
      resp_t e;
      e = model;
      e.err = 1'b1;
      e.cyc = cyc + 6;
      resp_q.push_back(e);
    end
    repeat (5) @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_done();

    // Reset in the middle of a cmd 4 read (read cycle 5)
    rsp_fifo = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    push_bus(1, 8'h04);
    issue(3'd4, 11, 0, 1);
    t = 0;
    while (rcyc != 5 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (rcyc != 5) fail("read_cycle5_timeout");
    reset_n = 1'b0;
    #1;
    check("midrst_bus_oe", 64'(dut.bus_oe_q), 64'(0));
    check("midrst_data_sync", 64'(data_sync), 64'(0));
    check("midrst_resp_valid", 64'(resp_valid), 64'(0));
    check("midrst_cmd_ready", 64'(cmd_ready), 64'(1));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rsp_fifo.delete();
    repeat (20) @(negedge clk);
    check("postrst_spec_q", 64'(spec_q), 64'(0));
    check("postrst_voice_i", 64'(voice_i), 64'(0));
    check("postrst_adc_min", 64'(adc_min), 64'(0));
    check("postrst_cmd_ready", 64'(cmd_ready), 64'(1));

    // Recovery after reset: bus test still works
    model = zero_resp();
    model.tok = 1'b1;
    push_bus(1, 8'h00); push_bus(0, 8'hA5);
    issue(3'd0, 4, 1, 1);
    wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
